// File: rtl/picoblaze_irq_ctrl_if.sv
// picoblaze_irq_ctrl_if
//   Bundles the KCPSM3 I/O port bus, the interrupt handshake and the
//   peripheral interrupt sources of picoblaze_irq_ctrl.
//   master : processor/peripheral side (drives port bus, ack, sources)
//   slave  : the interrupt controller
//   Signals:
//     irq_src[N_SRC]  peripheral interrupt sources (async, rising-edge)
//     port_id[8]      KCPSM3 port address
//     write_strobe    KCPSM3 output strobe
//     out_port[8]     KCPSM3 output data
//     in_port[8]      register read data (registered)
//     in_sel          previous-cycle port_id hit the register window
//     interrupt       to KCPSM3 interrupt input
//     interrupt_ack   from KCPSM3, 1-cycle pulse
interface picoblaze_irq_ctrl_if #(
  parameter int unsigned N_SRC = 8
);
  logic [N_SRC-1:0] irq_src;
  logic [7:0]       port_id;
  logic             write_strobe;
  logic [7:0]       out_port;
  logic [7:0]       in_port;
  logic             in_sel;
  logic             interrupt;
  logic             interrupt_ack;

  modport master (
    output irq_src, port_id, write_strobe, out_port, interrupt_ack,
    input  in_port, in_sel, interrupt
  );

  modport slave (
    input  irq_src, port_id, write_strobe, out_port, interrupt_ack,
    output in_port, in_sel, interrupt
  );
endinterface

// File: rtl/picoblaze_irq_ctrl.sv
// picoblaze_irq_ctrl
//   Interrupt controller for KCPSM3. Rising edges on irq_src are synchronised
//   and latched into PEND; enabled requests are arbitrated by fixed priority
//   (bit 0 highest) and presented on the single interrupt line, with an
//   assert / acknowledge / in-service handshake.
//   Register window at BASE_PORT (8 ports):
//     +0 MASK R/W, +1 PEND R, +2 CLEAR W1C, +3 VEC R, +4 CTRL R/W (bit0 GEN),
//     +5 LOST (only with IRQ_LOST_COUNT_EN defined), +6/+7 read 0.
//   Ports:
//     clk    system clock (posedge)
//     reset  asynchronous active-high reset
//     bus    picoblaze_irq_ctrl_if.slave (port bus, irq sources, handshake)
//   Build option: define IRQ_LOST_COUNT_EN for the saturating LOST counter.
module picoblaze_irq_ctrl #(
  parameter int unsigned N_SRC     = 8,
  parameter logic [7:0]  BASE_PORT = 8'hF0
) (
  input  logic                  clk,
  input  logic                  reset,
  picoblaze_irq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_INSERV
  } state_t;

  logic [N_SRC-1:0] r_sync1, r_sync2, r_prev;
  logic [N_SRC-1:0] r_pend, r_mask;
  logic             r_gen;
  state_t           r_state;
  logic [2:0]       r_vec;
  logic             r_int;
  logic [7:0]       r_in_port;
  logic             r_in_sel;

  logic             w_win, w_wr;
  logic [2:0]       w_off;
  logic [N_SRC-1:0] w_rise, w_clr, w_req;
  logic [7:0]       w_req8, w_pend8, w_mask8;
  logic [2:0]       w_vec;
  logic             w_found;
  logic             w_withdraw;
  logic [7:0]       w_lost;
  logic [7:0]       w_rd;

  assign w_win   = (bus.port_id[7:3] == BASE_PORT[7:3]);
  assign w_wr    = bus.write_strobe & w_win;
  assign w_off   = bus.port_id[2:0];
  assign w_rise  = r_sync2 & ~r_prev;
  assign w_clr   = (w_wr && (w_off == 3'd2)) ? bus.out_port[N_SRC-1:0] : '0;
  assign w_req   = r_pend & r_mask & {N_SRC{r_gen}};
  assign w_req8  = 8'(w_req);
  assign w_pend8 = 8'(r_pend);
  assign w_mask8 = 8'(r_mask);

  // Lowest set index wins.
  always_comb begin
    w_vec   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_req8[i] && !w_found) begin
        w_vec   = 3'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_withdraw = !w_pend8[r_vec] || !w_mask8[r_vec] || !r_gen;

  // Synchroniser, edge detect, pending and software registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_gen   <= 1'b0;
    end else begin
      r_sync1 <= bus.irq_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // A new edge overrides a simultaneous software clear.
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (w_wr && (w_off == 3'd0)) r_mask <= bus.out_port[N_SRC-1:0];
      if (w_wr && (w_off == 3'd4)) r_gen  <= bus.out_port[0];
    end
  end

`ifdef IRQ_LOST_COUNT_EN
  logic [7:0] r_lost;
  logic       w_lost_inc;

  assign w_lost_inc = |(w_rise & r_pend & ~w_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lost <= '0;
    end else if (w_wr && (w_off == 3'd5)) begin
      r_lost <= '0;
    end else if (w_lost_inc && (r_lost != 8'hFF)) begin
      r_lost <= r_lost + 8'd1;
    end
  end

  assign w_lost = r_lost;
`else
  assign w_lost = '0;
`endif

  // Interrupt handshake FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_int   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_vec   <= w_vec;
            r_int   <= 1'b1;
            r_state <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (bus.interrupt_ack) begin
            r_int   <= 1'b0;
            r_state <= S_INSERV;
          end else if (w_withdraw) begin
            r_int   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_INSERV: begin
          r_int <= 1'b0;
          if (!w_pend8[r_vec]) r_state <= S_IDLE;
        end
        default: begin
          r_int   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read mux.
  always_comb begin
    w_rd = '0;
    if (w_win) begin
      case (w_off)
        3'd0:    w_rd = w_mask8;
        3'd1:    w_rd = w_pend8;
        3'd3:    w_rd = {(r_state == S_INSERV), 4'b0000, r_vec};
        3'd4:    w_rd = {7'b0000000, r_gen};
        3'd5:    w_rd = w_lost;
        default: w_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_port <= '0;
      r_in_sel  <= 1'b0;
    end else begin
      r_in_port <= w_rd;
      r_in_sel  <= w_win;
    end
  end

  assign bus.in_port   = r_in_port;
  assign bus.in_sel    = r_in_sel;
  assign bus.interrupt = r_int;

endmodule
